// File: rtl/bicubic_pkg.sv
// Shared constants and types for the bicubic tap accumulator.
package bicubic_pkg;
  localparam int BICUBIC_TAPS      = 4;
  localparam int BICUBIC_FRAC_BITS = 7;

  typedef logic signed [17:0] prod_t;
  typedef logic signed [19:0] acc_t;
  typedef logic        [7:0]  pix_t;
endpackage

// File: rtl/sat_round_u8.sv
// One-lane finish: optional half-up rounding, arithmetic shift, clamp to UINT8.
// Rounding is enabled by defining BICUBIC_ACC_ROUND_EN; otherwise the shift truncates toward -inf.
module sat_round_u8 #(
  parameter int ACC_WIDTH = 20,
  parameter int FRAC_BITS = 7
) (
  input  logic signed [ACC_WIDTH-1:0] sum_i,
  output logic        [7:0]           pix_o
);
  // One guard bit so adding the rounding constant can never wrap.
  localparam int RW = ACC_WIDTH + 1;
`ifdef BICUBIC_ACC_ROUND_EN
  localparam logic signed [RW-1:0] RND = RW'(1) << (FRAC_BITS - 1);
`else
  localparam logic signed [RW-1:0] RND = '0;
`endif

  logic signed [RW-1:0] r, q;

  always_comb begin
    r = {sum_i[ACC_WIDTH-1], sum_i} + RND;
    q = r >>> FRAC_BITS;
    if (q[RW-1])           pix_o = 8'd0;
    else if (|q[RW-2:8])   pix_o = 8'd255;
    else                   pix_o = q[7:0];
  end
endmodule

// File: rtl/bicubic_tap_acc_2x.sv
// Two-lane bicubic tap accumulator: sums TAPS signed products per lane, then rounds,
// shifts and clamps to UINT8 onto a valid/ready stream. Rounding via BICUBIC_ACC_ROUND_EN.
module bicubic_tap_acc_2x
  import bicubic_pkg::*;
#(
  parameter int TAPS       = BICUBIC_TAPS,
  parameter int FRAC_BITS  = BICUBIC_FRAC_BITS,
  parameter int PROD_WIDTH = 18
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [PROD_WIDTH-1:0] s_ca_mul,
  input  logic signed [PROD_WIDTH-1:0] s_cb_mul,
  output logic                         m_valid,
  input  logic                         m_ready,
  output pix_t                         m_pix_a,
  output pix_t                         m_pix_b,
  output logic [$clog2(TAPS)-1:0]      m_tap_idx
);
  localparam int NUM_LANES = 2;
  localparam int ACC_WIDTH = PROD_WIDTH + $clog2(TAPS);
  localparam int TW        = $clog2(TAPS);
  localparam logic [TW-1:0] LAST_TAP = TW'(TAPS - 1);

  logic [TW-1:0] tap_q, tap_d;
  logic          accept, last_tap;
  logic          m_valid_q, m_valid_d;

  logic [NUM_LANES-1:0][PROD_WIDTH-1:0] prod;
  logic [NUM_LANES-1:0][ACC_WIDTH-1:0]  prod_x, sum, acc_q;
  logic [NUM_LANES-1:0][7:0]            pix, pix_q;

  assign prod     = {s_cb_mul, s_ca_mul};
  assign accept   = s_valid && s_ready;
  assign last_tap = (tap_q == LAST_TAP);

  // Tap counter FSM: state register
  always_ff @(posedge clk) begin
    if (!aresetn) tap_q <= '0;
    else          tap_q <= tap_d;
  end

  // Tap counter FSM: next state
  always_comb begin
    tap_d = tap_q;
    if (accept) tap_d = last_tap ? '0 : tap_q + TW'(1);
  end

  // Tap counter FSM: outputs
  always_comb begin
    s_ready   = !m_valid_q || m_ready;
    m_tap_idx = tap_q;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign prod_x[l] = {{(ACC_WIDTH-PROD_WIDTH){prod[l][PROD_WIDTH-1]}}, prod[l]};
    assign sum[l]    = acc_q[l] + prod_x[l];

    sat_round_u8 #(
      .ACC_WIDTH (ACC_WIDTH),
      .FRAC_BITS (FRAC_BITS)
    ) u_fin (
      .sum_i (sum[l]),
      .pix_o (pix[l])
    );
  end

  // Last tap never writes acc; its sum goes straight through the finish logic.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      acc_q <= '0;
    end else if (accept && !last_tap) begin
      for (int l = 0; l < NUM_LANES; l++)
        acc_q[l] <= (tap_q == '0) ? prod_x[l] : sum[l];
    end
  end

  always_comb begin
    m_valid_d = m_valid_q;
    if (accept && last_tap) m_valid_d = 1'b1;
    else if (m_ready)       m_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      m_valid_q <= 1'b0;
      pix_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      if (accept && last_tap) pix_q <= pix;
    end
  end

  assign m_valid = m_valid_q;
  assign m_pix_a = pix_q[0];
  assign m_pix_b = pix_q[1];
endmodule

// File: tb/tb_bicubic_tap_acc_2x.sv
// Scoreboard bench for bicubic_tap_acc_2x (TAPS=4, FRAC_BITS=7), directed and random.
module tb_bicubic_tap_acc_2x;
  localparam int TAPS = 4;
  localparam int FRAC = 7;
`ifdef BICUBIC_ACC_ROUND_EN
  localparam int RND = 1 << (FRAC - 1);
`else
  localparam int RND = 0;
`endif

  logic              clk = 1'b0;
  logic              aresetn = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic signed [17:0] s_ca_mul = '0;
  logic signed [17:0] s_cb_mul = '0;
  logic              m_valid;
  logic              m_ready;
  logic [7:0]        m_pix_a, m_pix_b;
  logic [1:0]        m_tap_idx;

  bicubic_tap_acc_2x dut (
    .clk(clk), .aresetn(aresetn), .s_valid(s_valid), .s_ready(s_ready),
    .s_ca_mul(s_ca_mul), .s_cb_mul(s_cb_mul), .m_valid(m_valid), .m_ready(m_ready),
    .m_pix_a(m_pix_a), .m_pix_b(m_pix_b), .m_tap_idx(m_tap_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_q[$];          // {pix_a, pix_b} packed as a*256+b
  int tb_tap = 0;
  int sum_a = 0, sum_b = 0;
  int ready_mode = 1;    // 0 low, 1 high, 2 random 70%

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference finish: floor((sum+rnd)/2^FRAC), clamped to [0,255].
  function automatic int finish(input int s);
    int r, q;
    r = s + RND;
    if (r >= 0) q = r / (1 << FRAC);
    else        q = -((-r + (1 << FRAC) - 1) / (1 << FRAC));
    if (q < 0)   return 0;
    if (q > 255) return 255;
    return q;
  endfunction

  // Single driver of m_ready, offset from the edge.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = ($urandom_range(0, 99) < 70);
      endcase
    end
  end

  // Monitor: a handshake seen at negedge completes on the next rising edge.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (aresetn && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pix_a", int'(m_pix_a), e / 256);
          check("pix_b", int'(m_pix_b), e % 256);
        end
      end
    end
  end

  // Called at posedge+1; leaves s_valid high so taps stream back to back.
  task automatic send_tap(input int ca, input int cb);
    int waited = 0;
    s_valid  = 1'b1;
    s_ca_mul = 18'(ca);
    s_cb_mul = 18'(cb);
    forever begin
      @(negedge clk);
      if (s_ready) begin
        check("tap_idx", int'(m_tap_idx), tb_tap);
        @(posedge clk); #1;
        break;
      end
      waited++;
      if (waited > 1000) begin
        check("accept_timeout", 0, 1);
        return;
      end
    end
    if (tb_tap == 0) begin sum_a = 0; sum_b = 0; end
    sum_a += ca;
    sum_b += cb;
    if (tb_tap == TAPS - 1) begin
      exp_q.push_back(finish(sum_a) * 256 + finish(sum_b));
      tb_tap = 0;
    end else begin
      tb_tap++;
    end
  endtask

  task automatic send_group(input int a0, a1, a2, a3, input int b0, b1, b2, b3);
    send_tap(a0, b0); send_tap(a1, b1); send_tap(a2, b2); send_tap(a3, b3);
  endtask

  task automatic idle_drain();
    int n = 0;
    s_valid = 1'b0;
    ready_mode = 1;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic int rprod();
    return $urandom_range(0, 255) * (int'($urandom_range(0, 511)) - 256);
  endfunction

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_pix_a", int'(m_pix_a), 0);
    check("rst_pix_b", int'(m_pix_b), 0);
    check("rst_tap_idx", int'(m_tap_idx), 0);
    check("rst_s_ready", int'(s_ready), 1);
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(posedge clk); #1;

    // Passthrough with one-cycle latency, then valid drops and pixels hold
    send_group(0, 12800, 0, 0, 0, 6400, 0, 0);
    s_valid = 1'b0;
    @(negedge clk);
    check("pass_latency_valid", int'(m_valid), 1);
    check("pass_pix_a", int'(m_pix_a), 100);
    check("pass_pix_b", int'(m_pix_b), 50);
    @(posedge clk); #1;
    @(negedge clk);
    check("pass_valid_drop", int'(m_valid), 0);
    check("pass_pix_hold", int'(m_pix_a), 100);
    @(posedge clk); #1;

    // Saturation both directions, rounding / truncation, negative clamp
    send_group(0, 40000, 0, 0, -5000, 0, 0, 0);
    send_group(64, 64, 64, 0, -64, 0, 0, 0);
    send_group(-131072, 131071, 127, 1, 255 * 128, 64, 0, -1);
    idle_drain();

    // Backpressure: hold the 100/50 pair while 8 taps wait
    ready_mode = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    send_group(0, 12800, 0, 0, 0, 6400, 0, 0);
    fork
      begin
        for (int i = 0; i < 8; i++) send_tap(rprod(), rprod());
        s_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("bp_valid", int'(m_valid), 1);
          check("bp_s_ready", int'(s_ready), 0);
          check("bp_pix_a", int'(m_pix_a), 100);
          check("bp_pix_b", int'(m_pix_b), 50);
        end
        ready_mode = 1;
      end
    join
    idle_drain();

    // Reset mid-accumulation discards the partial sum
    send_tap(5000, 5000);
    send_tap(5000, 5000);
    s_valid = 1'b0;
    aresetn = 1'b0;
    @(posedge clk); #1;
    aresetn = 1'b1;
    tb_tap = 0;
    @(negedge clk);
    check("mid_rst_valid", int'(m_valid), 0);
    check("mid_rst_tap_idx", int'(m_tap_idx), 0);
    @(posedge clk); #1;
    send_group(0, 12800, 0, 0, 0, 0, 0, 0);
    idle_drain();

    // Random streaming with random backpressure
    ready_mode = 2;
    for (int g = 0; g < 64; g++)
      for (int t = 0; t < TAPS; t++) send_tap(rprod(), rprod());
    idle_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
